// File: rtl/bram_seq_ctrl_pkg.sv
// Shared types and helpers for the BRAM sequencing controller:
// FSM state encoding, run-mode encoding and the address wrap helper.
package bram_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_WR_RD = 2'd0,
        MODE_WR    = 2'd1,
        MODE_RD    = 2'd2,
        MODE_BAD   = 2'd3
    } mode_e;

    // Window address base+idx folded back into 0..mem_size-1 with an explicit
    // compare, so non-power-of-two depths wrap correctly.
    function automatic int unsigned next_addr(input int unsigned base,
                                              input int unsigned idx,
                                              input int unsigned mem_size);
        int unsigned sum;
        sum = base + idx;
        if (sum >= mem_size) begin
            sum = sum - mem_size;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bram_seq_ctrl_if.sv
// Data-path bundle of the controller: write stream in, BRAM port 0, read stream out.
// master = controller side, slave = data-mover / memory side.
interface bram_seq_ctrl_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 7
);
    logic [DWIDTH-1:0] i_wdata;
    logic              i_wvalid;
    logic              o_wready;
    logic [AWIDTH-1:0] addr0;
    logic              ce0;
    logic              we0;
    logic [DWIDTH-1:0] d0;
    logic [DWIDTH-1:0] q0;
    logic              o_valid;
    logic              i_ready;
    logic [DWIDTH-1:0] o_mem_data;

    modport master (
        input  i_wdata, i_wvalid, q0, i_ready,
        output o_wready, addr0, ce0, we0, d0, o_valid, o_mem_data
    );

    modport slave (
        output i_wdata, i_wvalid, q0, i_ready,
        input  o_wready, addr0, ce0, we0, d0, o_valid, o_mem_data
    );
endinterface

// File: rtl/bram_seq_ctrl_sync_skid_fifo.sv
// Small register FIFO used as the read output buffer: push/pop with occupancy
// count, head word presented with valid/ready and held stable while stalled.
module sync_skid_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_ready_i,
    output logic                         pop_valid_o,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop;
    logic             push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_valid_o = (count_q != '0);
    assign pop         = pop_valid_o && pop_ready_i;
    assign push_ok     = push_i && ((count_q != CW'(DEPTH)) || pop);
    assign pop_data_o  = pop_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/bram_seq_ctrl.sv
// Run-triggered sequencer for one BRAM port: writes, reads or writes-then-reads
// a wrapped address window, with a credit-limited read pipeline into an output buffer.
module bram_seq_ctrl
    import bram_seq_ctrl_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 7,
    parameter int MEM_SIZE   = 128,
    parameter int OBUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [1:0]         i_mode,
    input  logic [AWIDTH-1:0]  i_base_addr,
    input  logic [AWIDTH:0]    i_num_cnt,
    output logic               o_idle,
    output logic               o_write,
    output logic               o_read,
    output logic               o_done,
    output logic               o_err,
    bram_seq_ctrl_if.master    bus
);
    localparam int CW = $clog2(OBUF_DEPTH + 1);

    state_e            state_q, state_d;
    mode_e             mode_q;
    mode_e             run_mode;
    logic [AWIDTH-1:0] base_q;
    logic [AWIDTH:0]   cnt_q;
    logic [AWIDTH:0]   idx_q, idx_d;
    logic              inflight_q;
    logic              err_q;
    logic [CW-1:0]     fifo_cnt;
    logic              run_start, wr_beat, rd_issue, last_idx, fifo_room;
    logic [AWIDTH-1:0] addr_cur;

    assign run_mode  = mode_e'(i_mode);
    assign run_start = (state_q == ST_IDLE) && i_run;
    assign wr_beat   = (state_q == ST_WRITE) && bus.i_wvalid;
    assign last_idx  = (idx_q + 1'b1) == cnt_q;
    // Credit check counts the word whose q0 is still on its way from the BRAM.
    assign fifo_room = (int'(fifo_cnt) + int'(inflight_q)) < OBUF_DEPTH;
    assign rd_issue  = (state_q == ST_READ) && fifo_room;
    assign addr_cur  = AWIDTH'(next_addr(32'(base_q), 32'(idx_q), unsigned'(MEM_SIZE)));
    assign o_err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_run && (run_mode != MODE_BAD)) begin
                    if (i_num_cnt == '0)          state_d = ST_DONE;
                    else if (run_mode == MODE_RD) state_d = ST_READ;
                    else                          state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_beat && last_idx) begin
                    state_d = (mode_q == MODE_WR_RD) ? ST_READ : ST_DONE;
                end
            end
            ST_READ:  if (rd_issue && last_idx) state_d = ST_DRAIN;
            ST_DRAIN: if ((fifo_cnt == '0) && !inflight_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (run_start) begin
            idx_d = '0;
        end else if (wr_beat) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end else if (rd_issue) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        o_idle       = 1'b0;
        o_write      = 1'b0;
        o_read       = 1'b0;
        o_done       = 1'b0;
        bus.o_wready = 1'b0;
        bus.ce0      = 1'b0;
        bus.we0      = 1'b0;
        bus.d0       = '0;
        bus.addr0    = '0;
        case (state_q)
            ST_IDLE:  o_idle = 1'b1;
            ST_WRITE: begin
                o_write      = 1'b1;
                bus.o_wready = 1'b1;
                bus.ce0      = bus.i_wvalid;
                bus.we0      = bus.i_wvalid;
                bus.d0       = bus.i_wdata;
                bus.addr0    = addr_cur;
            end
            ST_READ: begin
                o_read    = 1'b1;
                bus.ce0   = rd_issue;
                bus.addr0 = addr_cur;
            end
            ST_DRAIN: o_read = 1'b1;
            ST_DONE:  o_done = 1'b1;
            default:  o_idle = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_WR_RD;
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            inflight_q <= rd_issue;
            err_q      <= run_start && (run_mode == MODE_BAD);
            if (run_start) begin
                mode_q <= run_mode;
                base_q <= i_base_addr;
                cnt_q  <= i_num_cnt;
            end
        end
    end

    sync_skid_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (bus.q0),
        .pop_ready_i (bus.i_ready),
        .pop_valid_o (bus.o_valid),
        .pop_data_o  (bus.o_mem_data),
        .count_o     (fifo_cnt)
    );
endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Directed bench for bram_seq_ctrl with a behavioural single-port BRAM on port 0.
module tb_bram_seq_ctrl;
    localparam int DW  = 16;
    localparam int AW  = 7;
    localparam int MSZ = 128;
    localparam int OBD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_run = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [AW-1:0] i_base_addr = '0;
    logic [AW:0]   i_num_cnt = '0;
    logic          o_idle, o_write, o_read, o_done, o_err;

    bram_seq_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    bram_seq_ctrl #(
        .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MSZ), .OBUF_DEPTH(OBD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run       (i_run),
        .i_mode      (i_mode),
        .i_base_addr (i_base_addr),
        .i_num_cnt   (i_num_cnt),
        .o_idle      (o_idle),
        .o_write     (o_write),
        .o_read      (o_read),
        .o_done      (o_done),
        .o_err       (o_err),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MSZ];
    always @(posedge clk) begin
        if (bus.ce0) begin
            if (bus.we0) mem[bus.addr0] <= bus.d0;
            bus.q0 <= mem[bus.addr0];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every strobe/transfer at the falling edge.
    int cyc = 0, n_done = 0, n_err = 0, n_ce = 0, n_over = 0, n_full = 0, n_stab = 0;
    int outstanding = 0;
    bit acc_pend = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], rd_cyc[$], pop_data[$], pop_cyc[$];

    always @(negedge clk) begin
        cyc++;
        acc_pend = bus.o_wready && bus.i_wvalid;
        if (reset) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (bus.ce0) n_ce++;
            if (bus.ce0 && bus.we0) begin
                wr_addr.push_back(int'(bus.addr0));
                wr_data.push_back(int'(bus.d0));
                wr_cyc.push_back(cyc);
            end
            if (bus.ce0 && !bus.we0) begin
                rd_addr.push_back(int'(bus.addr0));
                rd_cyc.push_back(cyc);
                outstanding++;
            end
            if (stall_prev && (!bus.o_valid || bus.o_mem_data != stall_data)) n_stab++;
            if (bus.o_valid && bus.i_ready) begin
                pop_data.push_back(int'(bus.o_mem_data));
                pop_cyc.push_back(cyc);
                outstanding--;
            end
            if (outstanding > OBD)  n_over++;
            if (outstanding == OBD) n_full++;
            stall_prev = bus.o_valid && !bus.i_ready;
            stall_data = bus.o_mem_data;
            if (o_done) n_done++;
            if (o_err)  n_err++;
        end
    end

    // Stream driver: write data tracks accepted beats, valid/ready follow patterns.
    int wbeat = 0, wbeat0 = 0, dcyc = 0;
    logic [DW-1:0] wbase = '0;
    int wv_pat = 0, rdy_pat = 0;

    initial begin
        bus.i_wdata  = '0;
        bus.i_wvalid = 1'b1;
        bus.i_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dcyc++;
            if (acc_pend) wbeat++;
            bus.i_wdata  = wbase + DW'(wbeat - wbeat0);
            bus.i_wvalid = (wv_pat == 1) ? ((dcyc % 3) != 0) : 1'b1;
            case (rdy_pat)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'b0;
                default: bus.i_ready = dcyc[0];
            endcase
        end
    end

    task automatic start_run(input int mode, input int base, input int cnt);
        $display("run mode=%0d base=%0d cnt=%0d at cycle %0d", mode, base, cnt, cyc);
        wbeat0 = wbeat;
        @(posedge clk);
        #1;
        i_run       = 1'b1;
        i_mode      = 2'(mode);
        i_base_addr = AW'(base);
        i_num_cnt   = (AW + 1)'(cnt);
        @(posedge clk);
        #1;
        i_run = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_q(input string tag, input int q[$], input int from, input int n,
                           input int a0, input int m);
        check_val({tag, "_cnt"}, q.size() - from, n);
        for (int i = 0; i < n; i++) begin
            check_val(tag, (from + i < q.size()) ? q[from + i] : -1, (a0 + i) % m);
        end
    endtask

    int s_wr, s_rd, s_pop, s_done, s_ce, s_over, s_full, s_stab, s_err;

    task automatic snap();
        s_wr = wr_addr.size(); s_rd = rd_addr.size(); s_pop = pop_data.size();
        s_done = n_done; s_ce = n_ce; s_over = n_over; s_full = n_full;
        s_stab = n_stab; s_err = n_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_idle",    o_idle, 1);
        check_val("rst_write",   o_write, 0);
        check_val("rst_read",    o_read, 0);
        check_val("rst_done",    o_done, 0);
        check_val("rst_err",     o_err, 0);
        check_val("rst_wready",  bus.o_wready, 0);
        check_val("rst_addr0",   bus.addr0, 0);
        check_val("rst_ce0",     bus.ce0, 0);
        check_val("rst_we0",     bus.we0, 0);
        check_val("rst_d0",      bus.d0, 0);
        check_val("rst_valid",   bus.o_valid, 0);
        check_val("rst_memdata", bus.o_mem_data, 0);

        // 1: write-then-read of 100 words, data equals index
        wbase = 16'h0000; snap();
        start_run(0, 0, 100);
        @(negedge clk);
        check_val("t1_first_we",   bus.ce0 && bus.we0, 1);
        check_val("t1_first_addr", bus.addr0, 0);
        check_val("t1_first_d0",   bus.d0, 0);
        wait_done("t1", 400);
        check_q("t1_wr_addr", wr_addr, s_wr, 100, 0, MSZ);
        check_q("t1_wr_data", wr_data, s_wr, 100, 0, 1 << 20);
        check_q("t1_rd_addr", rd_addr, s_rd, 100, 0, MSZ);
        check_q("t1_rd_data", pop_data, s_pop, 100, 0, 1 << 20);
        check_val("t1_wr_span",  wr_cyc[s_wr + 99] - wr_cyc[s_wr], 99);
        check_val("t1_rd_lat",   pop_cyc[s_pop] - rd_cyc[s_rd], 2);
        check_val("t1_pop_span", pop_cyc[s_pop + 99] - pop_cyc[s_pop], 99);
        check_val("t1_done_cnt", n_done - s_done, 1);
        check_val("t1_idle_after", o_idle, 1);

        // 2: wrap across the top of the memory
        wbase = 16'hA000; snap();
        start_run(0, 120, 16);
        wait_done("t2", 200);
        check_q("t2_wr_addr", wr_addr, s_wr, 16, 120, MSZ);
        check_q("t2_wr_data", wr_data, s_wr, 16, 32'hA000, 1 << 20);
        check_q("t2_rd_addr", rd_addr, s_rd, 16, 120, MSZ);
        check_q("t2_rd_data", pop_data, s_pop, 16, 32'hA000, 1 << 20);

        // 3: read-only with a 20-cycle stall and then a toggling ready
        snap();
        start_run(2, 10, 40);
        repeat (6) @(posedge clk);
        #1 rdy_pat = 1;
        repeat (20) @(posedge clk);
        #1 rdy_pat = 2;
        wait_done("t3", 600);
        rdy_pat = 0;
        check_q("t3_rd_addr", rd_addr, s_rd, 40, 10, MSZ);
        check_q("t3_rd_data", pop_data, s_pop, 40, 10, 1 << 20);
        check_val("t3_overcommit", n_over - s_over, 0);
        check_val("t3_buf_filled", 32'((n_full - s_full) > 0), 1);
        check_val("t3_stall_stable", n_stab - s_stab, 0);
        check_val("t3_no_writes", wr_addr.size() - s_wr, 0);

        // 4: write-only with a gap every third cycle
        wv_pat = 1; wbase = 16'h5000; snap();
        start_run(1, 60, 10);
        wait_done("t4", 100);
        wv_pat = 0;
        check_q("t4_wr_addr", wr_addr, s_wr, 10, 60, MSZ);
        check_q("t4_wr_data", wr_data, s_wr, 10, 32'h5000, 1 << 20);
        check_val("t4_no_reads", rd_addr.size() - s_rd, 0);

        // 5a: zero count finishes immediately without touching memory
        snap();
        start_run(0, 5, 0);
        @(negedge clk);
        check_val("t5_done_now", o_done, 1);
        @(negedge clk);
        check_val("t5_done_pulse", o_done, 0);
        check_val("t5_idle", o_idle, 1);
        @(negedge clk);
        check_val("t5_no_ce", n_ce - s_ce, 0);

        // 5b: illegal mode pulses o_err and stays idle
        snap();
        start_run(3, 0, 5);
        @(negedge clk);
        check_val("t5_err_now", o_err, 1);
        check_val("t5_err_idle", o_idle, 1);
        @(negedge clk);
        check_val("t5_err_pulse", o_err, 0);
        check_val("t5_err_still_idle", o_idle, 1);
        check_val("t5_err_no_ce", n_ce - s_ce, 0);
        check_val("t5_err_no_done", n_done - s_done, 0);

        // 6: reset on the fifth read, then a clean run
        snap();
        start_run(2, 20, 30);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1;
            if (rd_addr.size() - s_rd >= 5) found = 1'b1;
        end
        check_val("t6_fifth_read", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t6_rst_idle",    o_idle, 1);
        check_val("t6_rst_read",    o_read, 0);
        check_val("t6_rst_done",    o_done, 0);
        check_val("t6_rst_ce0",     bus.ce0, 0);
        check_val("t6_rst_addr0",   bus.addr0, 0);
        check_val("t6_rst_valid",   bus.o_valid, 0);
        check_val("t6_rst_memdata", bus.o_mem_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t6_no_done", n_done - s_done, 0);
        check_val("t6_idle_after", o_idle, 1);
        check_val("t6_no_valid", bus.o_valid, 0);

        wbase = 16'h7700; snap();
        start_run(0, 100, 8);
        wait_done("t6b", 200);
        check_q("t6_wr_addr", wr_addr, s_wr, 8, 100, MSZ);
        check_q("t6_wr_data", wr_data, s_wr, 8, 32'h7700, 1 << 20);
        check_q("t6_rd_addr", rd_addr, s_rd, 8, 100, MSZ);
        check_q("t6_rd_data", pop_data, s_pop, 8, 32'h7700, 1 << 20);
        check_val("t6_done_cnt", n_done - s_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_seq_ctrl.md
# bram_seq_ctrl

Parametrised sequencing controller for a single-port BRAM: on one `i_run` pulse it writes, reads, or writes-then-reads a contiguous address window of `i_num_cnt` words starting at `i_base_addr`. It wraps at `MEM_SIZE`. Write data is accepted through a valid/ready stream and read data leaves through a valid/ready stream with backpressure. It sits between a data-mover and port 0 of the team's `true_dpbram`, and supersedes the fixed write-then-read controller.

## Interface
Parameters:
- `DWIDTH`, 16, data word width
- `AWIDTH`, 7, address width; `MEM_SIZE` <= 2**`AWIDTH`
- `MEM_SIZE`, 128, memory depth in words; need not be a power of 2
- `OBUF_DEPTH`, 4, read output buffer entries; legal range 2..16; >= 3 gives full read throughput

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_run`  in  1  start pulse; sampled only in IDLE
- `i_mode`  in  2  0 write-then-read, 1 write-only, 2 read-only, 3 illegal
- `i_base_addr`  in  AWIDTH  first address, must be < `MEM_SIZE`
- `i_num_cnt`  in  AWIDTH+1  word count, 0..`MEM_SIZE`
- `o_idle` / `o_write` / `o_read` / `o_done`  out  1  state flags; `o_done` is a single-cycle pulse
- `o_err`  out  1  single-cycle pulse when `i_run` arrives with mode 3
- `i_wdata`  in  DWIDTH, `i_wvalid`  in  1, `o_wready`  out  1  write stream
- `addr0`  out  AWIDTH, `ce0`  out  1, `we0`  out  1, `d0`  out  DWIDTH, `q0`  in  DWIDTH  BRAM port
- `o_valid`  out  1, `i_ready`  in  1, `o_mem_data`  out  DWIDTH  read stream

## Operation
- The FSM has five states: IDLE, WRITE, READ, DRAIN, DONE.
- In IDLE with `i_run`=1, the block latches the mode, base address and count.
  - Mode 0 or 1 goes to WRITE.
  - Mode 2 goes to READ.
  - Count 0 goes straight to DONE with no memory access.
  - Mode 3 stays in IDLE and pulses `o_err`.
- `i_run` is ignored in every state other than IDLE.
- WRITE:
  - `o_wready`=1.
  - `ce0`=`we0`=`i_wvalid`, `d0`=`i_wdata`, `addr0`=current address.
  - The index advances only on an accepted beat; gaps in `i_wvalid` produce no strobe.
  - After the last beat, mode 0 goes to READ and mode 1 goes to DONE.
- READ:
  - The block issues `ce0`=1, `we0`=0 only while (buffered + in-flight) < `OBUF_DEPTH`.
  - After the last issue it goes to DRAIN.
- DRAIN holds until the buffer is empty and nothing is in flight, then goes to DONE.
- DONE lasts one cycle with `o_done`=1, then returns to IDLE.
- Address is `base` + `idx`. When the sum reaches `MEM_SIZE`, subtract `MEM_SIZE`; this wrap is an explicit compare, not natural overflow.
- Read data order equals address issue order; no word is dropped or duplicated.
- State flags are decoded from state: `o_idle`=IDLE, `o_write`=WRITE, `o_read`=READ or DRAIN.
- `addr0`, `ce0`, `we0` and `d0` are combinational from state, counters and handshake inputs.

## Timing
- Reset values: state IDLE and `o_idle`=1. Every other output is 0: `o_write`, `o_read`, `o_done`, `o_err`, `o_wready`, `addr0`, `ce0`, `we0`, `d0`, `o_valid`, `o_mem_data`.
- Start latency: if `i_run` is sampled at edge k, the first memory cycle is the cycle after edge k.
- The BRAM returns `q0` in the cycle after `ce0`. `q0` is pushed into the buffer at the end of that cycle, so `o_valid` rises 2 cycles after the read issue.
- Throughput is one word per cycle for writes with `i_wvalid` held high. Reads also run at one word per cycle with `i_ready` held high when `OBUF_DEPTH` >= 3.
- While `o_valid`=1 and `i_ready`=0, `o_mem_data` stays stable.
- A simultaneous push and pop leaves the buffer occupancy unchanged.
- Reset asserted mid-operation: at the next edge every output takes its reset value, in-flight and buffered data are discarded, and no `o_done` is produced.

## Structure
- Shared package holds:
  - FSM state encoding
  - mode encoding
  - a `next_addr` wrap helper
- One sub-module, `sync_skid_fifo`: parametrised width and depth, synchronous active-high reset. It exposes push/pop, count, and registered output with valid/ready. The controller uses it as the read output buffer.

## Test plan
1. Mode 0, base 0, count 100, `i_wvalid`=1 with data equal to the index, `i_ready`=1.
   - Required: writes to addresses 0..99, then reads returning 0..99 in order, then one `o_done` pulse.
2. Wrap with base 120, count 16, default depth 128.
   - Required: addresses 120..127 then 0..7, and the read-back data matches.
3. Backpressure: hold `i_ready` low for 20 cycles mid-read, then toggle it.
   - Required: at most `OBUF_DEPTH` reads outstanding, `o_mem_data` stable while stalled, all words delivered in order.
4. Write stream with `i_wvalid` gaps every third cycle, count 10.
   - Required: exactly 10 `we0` strobes at consecutive addresses.
5. Boundary inputs:
   - Count 0 in mode 0: `o_done` one cycle after `i_run`, `ce0` never asserted.
   - Mode 3: `o_err` pulses, block stays IDLE.
6. Reset asserted at the 5th read.
   - Required: all outputs at reset values next edge, `o_idle`=1, no `o_done`, and a new run afterwards behaves correctly.
